dm_arbiter: RTL and testbench

//   Shares the single-port data memory between the cpu (primary master) and a

---
 rtl/dm_arb_pkg.sv | 21 ++
 rtl/dm_arb_starve_cnt.sv | 41 ++++
 rtl/dm_arbiter.sv | 143 ++++++++++++++
 tb/tb_dm_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types for the data-memory arbiter.
//   state_t  debug-port FSM encoding (IDLE, RD_WAIT, ACK)
//   grant_t  bus owner for the current cycle
//   NB_WAIT  width of the starvation counter (covers MAX_WAIT up to MAX_WAIT_LIMIT)
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_t;

  localparam int MAX_WAIT_LIMIT = 15;
  localparam int NB_WAIT        = $clog2(MAX_WAIT_LIMIT + 1);

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// dm_arb_starve_cnt: counts cycles a pending debug request loses to the cpu
// and flags when it has waited MAX_WAIT cycles, forcing the next grant.
// Ports:
//   i_clk, i_reset   clock, async active-low reset
//   i_dbg_req        raw debug request (low clears the count)
//   i_dbg_pend       debug request waiting in IDLE
//   i_cpu_req        cpu wants the bus this cycle
//   i_dbg_gnt        debug owns the bus this cycle (clears the count)
//   o_expired        wait count has reached MAX_WAIT
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4  // legal 1..15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_dbg_req,
  input  logic i_dbg_pend,
  input  logic i_cpu_req,
  input  logic i_dbg_gnt,
  output logic o_expired
);

  localparam logic [NB_WAIT-1:0] WAIT_LIM = NB_WAIT'(MAX_WAIT);

  logic [NB_WAIT-1:0] wait_cnt;

  // Saturating: the count holds at the limit until the forced grant clears it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt <= '0;
    end else if (!i_dbg_req || i_dbg_gnt) begin
      wait_cnt <= '0;
    end else if (i_dbg_pend && i_cpu_req && (wait_cnt != WAIT_LIM)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign o_expired = (wait_cnt == WAIT_LIM);

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the cpu (fixed
// priority) and a debug/host port. A debug request denied MAX_WAIT times is
// forced through, stalling the cpu for that one cycle.
// Ports:
//   i_clk, i_reset                   clock, async active-low reset
//   i_cpu_wr/rd/addr/data            cpu access; o_cpu_data read data,
//   o_cpu_stall                      cpu denied this cycle (cpu holds request)
//   i_dbg_req/we/addr/wdata          debug op, request held until o_dbg_ack
//   o_dbg_ack, o_dbg_rdata           completion pulse, registered read data
//   o_mem_addr/data/wr/rd, i_mem_data  memory side (read data 1 cycle latency)
//   o_stall_count                    cpu stall cycles
// Build option: define DM_ARB_STATS_EN to include the saturating stall counter;
// otherwise o_stall_count is tied to zero.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NB_DATA    = 16,
  parameter int NB_ADDRESS = 11,
  parameter int MAX_WAIT   = 4,
  parameter int NB_STAT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpu_wr,
  input  logic                  i_cpu_rd,
  input  logic [NB_ADDRESS-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0]    i_cpu_data,
  output logic [NB_DATA-1:0]    o_cpu_data,
  output logic                  o_cpu_stall,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [NB_ADDRESS-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0]    i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic [NB_DATA-1:0]    o_dbg_rdata,
  output logic [NB_ADDRESS-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]    o_mem_data,
  output logic                  o_mem_wr,
  output logic                  o_mem_rd,
  input  logic [NB_DATA-1:0]    i_mem_data,
  output logic [NB_STAT-1:0]    o_stall_count
);

  state_t state, state_nxt;
  grant_t grant;
  logic   cpu_req;
  logic   dbg_pend;
  logic   dbg_gnt;
  logic   wait_expired;

  assign cpu_req  = i_cpu_wr | i_cpu_rd;
  // New debug ops are only accepted from IDLE; a request still high during
  // RD_WAIT/ACK is the tail of the op in flight.
  assign dbg_pend = i_dbg_req & (state == ST_IDLE);
  assign grant    = (dbg_pend & (~cpu_req | wait_expired)) ? GNT_DBG : GNT_CPU;
  assign dbg_gnt  = (grant == GNT_DBG);

  dm_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_dbg_req  (i_dbg_req),
    .i_dbg_pend (dbg_pend),
    .i_cpu_req  (cpu_req),
    .i_dbg_gnt  (dbg_gnt),
    .o_expired  (wait_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_dbg_ack = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg_gnt) begin
          state_nxt = i_dbg_we ? ST_ACK : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        o_dbg_ack = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Memory returns the debug read word during RD_WAIT; hold it for the ack.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_dbg_rdata <= '0;
    end else if (state == ST_RD_WAIT) begin
      o_dbg_rdata <= i_mem_data;
    end
  end

  // An idle bus still presents the cpu address/data with strobes low.
  // A cpu write and read in the same cycle issue only the write.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_data = i_cpu_data;
    o_mem_wr   = i_cpu_wr;
    o_mem_rd   = i_cpu_rd & ~i_cpu_wr;
    if (dbg_gnt) begin
      o_mem_addr = i_dbg_addr;
      o_mem_data = i_dbg_wdata;
      o_mem_wr   = i_dbg_we;
      o_mem_rd   = ~i_dbg_we;
    end
  end

  assign o_cpu_data  = i_mem_data;
  assign o_cpu_stall = cpu_req & dbg_gnt;

`ifdef DM_ARB_STATS_EN
  logic [NB_STAT-1:0] stall_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_count <= '0;
    end else if (o_cpu_stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign o_stall_count = stall_count;
`else
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  localparam int NB_DATA    = 16;
  localparam int NB_ADDRESS = 11;
  localparam int MAX_WAIT   = 4;
  localparam int NB_STAT    = 16;
  localparam int DEPTH      = 2 ** NB_ADDRESS;
`ifdef DM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_reset = 1'b0;
  logic                  i_cpu_wr = 1'b0, i_cpu_rd = 1'b0;
  logic [NB_ADDRESS-1:0] i_cpu_addr = '0;
  logic [NB_DATA-1:0]    i_cpu_data = '0;
  logic [NB_DATA-1:0]    o_cpu_data;
  logic                  o_cpu_stall;
  logic                  i_dbg_req = 1'b0, i_dbg_we = 1'b0;
  logic [NB_ADDRESS-1:0] i_dbg_addr = '0;
  logic [NB_DATA-1:0]    i_dbg_wdata = '0;
  logic                  o_dbg_ack;
  logic [NB_DATA-1:0]    o_dbg_rdata;
  logic [NB_ADDRESS-1:0] o_mem_addr;
  logic [NB_DATA-1:0]    o_mem_data;
  logic                  o_mem_wr, o_mem_rd;
  logic [NB_DATA-1:0]    i_mem_data;
  logic [NB_STAT-1:0]    o_stall_count;

  always #5 i_clk = ~i_clk;

  dm_arbiter #(
    .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .MAX_WAIT(MAX_WAIT), .NB_STAT(NB_STAT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cpu_wr(i_cpu_wr), .i_cpu_rd(i_cpu_rd), .i_cpu_addr(i_cpu_addr),
    .i_cpu_data(i_cpu_data), .o_cpu_data(o_cpu_data), .o_cpu_stall(o_cpu_stall),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_wr(o_mem_wr),
    .o_mem_rd(o_mem_rd), .i_mem_data(i_mem_data), .o_stall_count(o_stall_count)
  );

  // Environment: single-port RAM with one cycle read latency.
  logic [NB_DATA-1:0] ram [DEPTH];
  logic [NB_DATA-1:0] ram_q = '0;
  always @(posedge i_clk) begin
    if (o_mem_wr) ram[o_mem_addr] <= o_mem_data;
    else if (o_mem_rd) ram_q <= ram[o_mem_addr];
  end
  assign i_mem_data = ram_q;

  // Reference memory contents as the masters should see them.
  logic [NB_DATA-1:0] ref_mem [DEPTH];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic               is_rd;
    logic [NB_DATA-1:0] data;
    int                 issue;
    int                 exp_cyc;   // -1: only latency bounds are known
    int                 max_lat;
  } dbg_exp_t;

  dbg_exp_t           dbg_q[$];
  logic [NB_DATA-1:0] cpu_q[$];
  dbg_exp_t           mon_e;
  logic               cpu_chk_pend = 1'b0;
  logic               prev_stall = 1'b0;
  logic               mon_en = 1'b0;
  int                 stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_dbg(input logic is_rd, input logic [NB_DATA-1:0] d,
                          input int issue, input int exp_cyc, input int max_lat);
    dbg_exp_t e;
    e.is_rd = is_rd; e.data = d; e.issue = issue; e.exp_cyc = exp_cyc; e.max_lat = max_lat;
    dbg_q.push_back(e);
  endtask

  task automatic cyc_start();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor/scoreboard: pops expected debug completions on ack, checks cpu
  // read data one cycle after an accepted read, tracks cpu writes.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_dbg_ack) begin
        if (dbg_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dbg_ack_unexpected @cyc %0d: ack with no outstanding op", cyc);
        end else begin
          mon_e = dbg_q.pop_front();
          if (mon_e.exp_cyc >= 0) begin
            chk("dbg_ack_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
          end else begin
            tests++;
            if ((cyc - mon_e.issue) > mon_e.max_lat || (cyc - mon_e.issue) < (mon_e.is_rd ? 2 : 1)) begin
              fails++;
              $display("FAIL dbg_ack_latency: got %0d cycles, required %0d..%0d",
                       cyc - mon_e.issue, mon_e.is_rd ? 2 : 1, mon_e.max_lat);
            end
          end
          if (mon_e.is_rd) chk("dbg_rdata", 32'(o_dbg_rdata), 32'(mon_e.data));
        end
      end
      if (cpu_chk_pend) chk("cpu_rdata", 32'(o_cpu_data), 32'(cpu_q.pop_front()));
      cpu_chk_pend = 1'b0;
      if (i_reset && i_cpu_rd && !i_cpu_wr && !o_cpu_stall) begin
        cpu_q.push_back(ref_mem[i_cpu_addr]);
        cpu_chk_pend = 1'b1;
      end
      if (i_reset && i_cpu_wr && !o_cpu_stall) ref_mem[i_cpu_addr] = i_cpu_data;
      if (o_cpu_stall) begin
        stall_seen++;
        chk("stall_not_consecutive", 32'(prev_stall), 32'(0));
        chk("stall_needs_cpu_req", 32'(i_cpu_wr | i_cpu_rd), 32'(1));
      end
      prev_stall = o_cpu_stall;
    end
  end

  // cpu reads every cycle while a debug read waits: MAX_WAIT denials, then
  // a single forced grant; the stalled cpu address is reissued afterwards.
  task automatic run_starve(input logic [NB_ADDRESS-1:0] da, input logic [NB_ADDRESS-1:0] ca0);
    logic [NB_ADDRESS-1:0] ca;
    logic                  exp_stall;
    ca = ca0;
    for (int i = 0; i <= MAX_WAIT + 2; i++) begin
      cyc_start();
      if (i == 0) begin
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = da;
        push_dbg(1'b1, ref_mem[da], cyc, cyc + MAX_WAIT + 2, 0);
      end
      i_cpu_rd = 1'b1; i_cpu_wr = 1'b0; i_cpu_addr = ca;
      #2;
      exp_stall = (i == MAX_WAIT);
      chk("starve_stall", 32'(o_cpu_stall), 32'(exp_stall));
      chk("starve_mem_addr", 32'(o_mem_addr), 32'(exp_stall ? da : ca));
      chk("starve_mem_rd", 32'(o_mem_rd), 32'(1));
      if (!o_cpu_stall) ca = ca + 1'b1;
    end
    cyc_start();
    i_cpu_rd = 1'b0; i_dbg_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    bit                    cpu_hold, dbg_active;
    int                    gap, dbg_issue, r;
    logic                  creq;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = NB_DATA'(i * 7 + 16'h1000);
      ref_mem[i] = NB_DATA'(i * 7 + 16'h1000);
    end

    // Reset state
    repeat (3) @(posedge i_clk);
    #3;
    chk("rst_ack", 32'(o_dbg_ack), 32'(0));
    chk("rst_rdata", 32'(o_dbg_rdata), 32'(0));
    chk("rst_stall_count", 32'(o_stall_count), 32'(0));
    chk("rst_mem_wr", 32'(o_mem_wr), 32'(0));
    chk("rst_mem_rd", 32'(o_mem_rd), 32'(0));
    cyc_start();
    i_reset = 1'b1;
    mon_en  = 1'b1;

    // 1: debug write with cpu idle
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 11'h003; i_dbg_wdata = 16'h12A5;
    ref_mem[11'h003] = 16'h12A5;
    push_dbg(1'b0, '0, cyc, cyc + 1, 0);
    #2;
    chk("t1_mem_wr", 32'(o_mem_wr), 32'(1));
    chk("t1_mem_rd", 32'(o_mem_rd), 32'(0));
    chk("t1_mem_addr", 32'(o_mem_addr), 32'h003);
    chk("t1_mem_data", 32'(o_mem_data), 32'h12A5);
    chk("t1_no_stall", 32'(o_cpu_stall), 32'(0));
    cyc_start();
    #2;
    chk("t1_ack_cycle_no_access", 32'(o_mem_wr), 32'(0));
    cyc_start();
    i_dbg_req = 1'b0;

    // 2: debug read returns the written word two cycles after grant
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 11'h003;
    push_dbg(1'b1, ref_mem[11'h003], cyc, cyc + 2, 0);
    #2;
    chk("t2_mem_rd", 32'(o_mem_rd), 32'(1));
    chk("t2_mem_wr", 32'(o_mem_wr), 32'(0));
    chk("t2_mem_addr", 32'(o_mem_addr), 32'h003);
    cyc_start();
    #2;
    chk("t2_rdwait_bus_idle", 32'(o_mem_rd), 32'(0));
    cyc_start();
    cyc_start();
    i_dbg_req = 1'b0;

    // 4: request held through ack gives no second access; reassert -> new op
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 11'h005; i_dbg_wdata = 16'hBEEF;
    ref_mem[11'h005] = 16'hBEEF;
    push_dbg(1'b0, '0, cyc, cyc + 1, 0);
    cyc_start();
    #2;
    chk("t4_held_no_wr", 32'(o_mem_wr), 32'(0));
    chk("t4_held_no_rd", 32'(o_mem_rd), 32'(0));
    cyc_start();
    i_dbg_req = 1'b0;
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 11'h005;
    push_dbg(1'b1, ref_mem[11'h005], cyc, cyc + 2, 0);
    #2;
    chk("t4_new_op_rd", 32'(o_mem_rd), 32'(1));
    chk("t4_new_op_addr", 32'(o_mem_addr), 32'h005);
    cyc_start();
    cyc_start();
    cyc_start();
    i_dbg_req = 1'b0;

    // Simultaneous cpu write and read: write wins on the memory side
    cyc_start();
    i_cpu_wr = 1'b1; i_cpu_rd = 1'b1; i_cpu_addr = 11'h500; i_cpu_data = 16'h5A5A;
    #2;
    chk("wr_prec_wr", 32'(o_mem_wr), 32'(1));
    chk("wr_prec_rd", 32'(o_mem_rd), 32'(0));
    chk("wr_prec_data", 32'(o_mem_data), 32'h5A5A);
    cyc_start();
    i_cpu_wr = 1'b0; i_cpu_rd = 1'b1; i_cpu_addr = 11'h500;
    cyc_start();
    i_cpu_rd = 1'b0;

    // 3: starvation, MAX_WAIT denials then forced grant
    run_starve(11'h003, 11'h400);

    // 5: reset during RD_WAIT drops the op
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 11'h003;
    push_dbg(1'b1, ref_mem[11'h003], cyc, cyc + 2, 0);
    cyc_start();
    #2;
    i_reset = 1'b0;
    i_dbg_req = 1'b0;
    dbg_q.delete();
    stall_seen = 0;
    #1;
    chk("t5_rst_ack", 32'(o_dbg_ack), 32'(0));
    chk("t5_rst_rdata", 32'(o_dbg_rdata), 32'(0));
    chk("t5_rst_stall_count", 32'(o_stall_count), 32'(0));
    cyc_start();
    cyc_start();
    i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_start();
      #2;
      chk("t5_idle_no_rd", 32'(o_mem_rd), 32'(0));
    end
    cyc_start();
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 11'h007; i_dbg_wdata = 16'h0707;
    ref_mem[11'h007] = 16'h0707;
    push_dbg(1'b0, '0, cyc, cyc + 1, 0);
    #2;
    chk("t5_idle_grant", 32'(o_mem_wr), 32'(1));
    cyc_start();
    cyc_start();
    i_dbg_req = 1'b0;

    // 6: three forced grants
    for (int k = 0; k < 3; k++) run_starve(NB_ADDRESS'(8 + k), NB_ADDRESS'(11'h420 + 16 * k));
    cyc_start();
    #2;
    chk("t6_stall_count", 32'(o_stall_count), STATS ? 32'(3) : 32'(0));

    // Random traffic
    cpu_hold = 1'b0; dbg_active = 1'b0; gap = 1; dbg_issue = 0;
    for (int n = 0; n < 800; n++) begin
      cyc_start();
      if (!cpu_hold) begin
        r = $urandom_range(0, 9);
        i_cpu_wr   = (r >= 6);
        i_cpu_rd   = (r >= 2 && r < 6) || (r == 9);
        i_cpu_addr = NB_ADDRESS'(11'h400 + $urandom_range(0, 15));
        i_cpu_data = NB_DATA'($urandom);
      end
      creq = i_cpu_wr | i_cpu_rd;
      if (!dbg_active) begin
        if (gap > 0) begin
          i_dbg_req = 1'b0;
          gap--;
        end else begin
          i_dbg_req   = 1'b1;
          i_dbg_we    = 1'($urandom_range(0, 1));
          i_dbg_addr  = NB_ADDRESS'($urandom_range(0, 15));
          i_dbg_wdata = NB_DATA'($urandom);
          if (i_dbg_we) begin
            ref_mem[i_dbg_addr] = i_dbg_wdata;
            push_dbg(1'b0, '0, cyc, creq ? -1 : cyc + 1, MAX_WAIT + 1);
          end else begin
            push_dbg(1'b1, ref_mem[i_dbg_addr], cyc, creq ? -1 : cyc + 2, MAX_WAIT + 2);
          end
          dbg_active = 1'b1;
          dbg_issue  = cyc;
        end
      end
      #2;
      cpu_hold = o_cpu_stall;
      if (dbg_active && o_dbg_ack) begin
        dbg_active = 1'b0;
        gap = $urandom_range(1, 4);
      end else if (dbg_active && (cyc - dbg_issue) > MAX_WAIT + 2) begin
        $display("FAIL dbg_timeout: no ack %0d cycles after issue, required <= %0d",
                 cyc - dbg_issue, MAX_WAIT + 2);
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1);
      end
    end

    // Drain
    for (int n = 0; n < 8; n++) begin
      cyc_start();
      if (!cpu_hold) begin
        i_cpu_wr = 1'b0; i_cpu_rd = 1'b0;
      end
      if (!dbg_active) i_dbg_req = 1'b0;
      #2;
      cpu_hold = o_cpu_stall;
      if (dbg_active && o_dbg_ack) dbg_active = 1'b0;
    end
    chk("drain_dbg_q_empty", 32'(dbg_q.size()), 32'(0));
    chk("final_stall_count", 32'(o_stall_count), STATS ? 32'(stall_seen) : 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
